// File: rtl/sdvm_div_pipe.sv
// Signed-digit vector multiply stage: a delayed digit selects +/-1, +/-2, 0 or
// illegal, and that digit is applied to a redundant (plus/minus plane) operand.
module sdvm_div_pipe #(
    parameter int unsigned NUM_BITS = 4,
    parameter int unsigned DELAY    = 1,
    parameter int unsigned RADIX4   = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                asyn_reset,
    input  logic                enable,
    input  logic [NUM_BITS-1:0] vec_in_plus,
    input  logic [NUM_BITS-1:0] vec_in_minus,
    input  logic [2:0]          digit_select,
    input  logic                in_valid,
    input  logic                clr_err,
    output logic [NUM_BITS-1:0] vec_out_plus,
    output logic [NUM_BITS-1:0] vec_out_minus,
    output logic                out_valid,
    output logic                digit_err,
    output logic                err_sticky,
    output logic [CNT_W-1:0]    digit_count
);

    localparam int unsigned SEL_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SEL_W-1:0]    r_dly_sel [DELAY];
    logic                r_dly_vld [DELAY];
    logic [NUM_BITS-1:0] r_out_plus;
    logic [NUM_BITS-1:0] r_out_minus;
    logic                r_out_valid;
    logic                r_digit_err;
    logic                r_err_sticky;
    logic [CNT_W-1:0]    r_digit_count;

    logic [SEL_W-1:0]    w_last_sel;
    logic                w_last_vld;
    logic                w_mag2;
    logic [NUM_BITS-1:0] w_scaled_plus;
    logic [NUM_BITS-1:0] w_scaled_minus;
    logic [NUM_BITS-1:0] w_plus;
    logic [NUM_BITS-1:0] w_minus;
    logic                w_err;
    logic                w_nonzero;

    assign w_last_sel = r_dly_sel[DELAY-1];
    assign w_last_vld = r_dly_vld[DELAY-1];

    // Digit delay line: shifts {digit_select, in_valid} one stage per enabled edge.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            for (int i = 0; i < int'(DELAY); i++) begin
                r_dly_sel[i] <= '0;
                r_dly_vld[i] <= 1'b0;
            end
        end else if (enable) begin
            r_dly_sel[0] <= digit_select;
            r_dly_vld[0] <= in_valid;
            for (int i = 1; i < int'(DELAY); i++) begin
                r_dly_sel[i] <= r_dly_sel[i-1];
                r_dly_vld[i] <= r_dly_vld[i-1];
            end
        end
    end

    // Digit application: optional x2 shift first, then optional complement.
    always_comb begin
        w_plus         = '0;
        w_minus        = '0;
        w_err          = 1'b0;
        w_nonzero      = 1'b0;
        w_mag2         = (RADIX4 != 0) && w_last_sel[2];
        w_scaled_plus  = w_mag2 ? {vec_in_plus[NUM_BITS-2:0], 1'b0}  : vec_in_plus;
        w_scaled_minus = w_mag2 ? {vec_in_minus[NUM_BITS-2:0], 1'b0} : vec_in_minus;
        if (w_last_vld) begin
            case (w_last_sel[1:0])
                2'b10: begin
                    w_plus    = w_scaled_plus;
                    w_minus   = w_scaled_minus;
                    w_nonzero = 1'b1;
                end
                2'b01: begin
                    w_plus    = ~w_scaled_plus;
                    w_minus   = ~w_scaled_minus;
                    w_nonzero = 1'b1;
                end
                2'b11: begin
                    w_err = 1'b1;
                end
                default: begin
                    w_plus  = '0;
                    w_minus = '0;
                end
            endcase
        end
    end

    // Result registers, error flags and saturating nonzero-digit counter.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_out_plus    <= '0;
            r_out_minus   <= '0;
            r_out_valid   <= 1'b0;
            r_digit_err   <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_digit_count <= '0;
        end else if (enable) begin
            r_out_plus  <= w_plus;
            r_out_minus <= w_minus;
            r_out_valid <= w_last_vld;
            r_digit_err <= w_err;
            if (w_err) begin
                r_err_sticky <= 1'b1;
            end else if (clr_err) begin
                r_err_sticky <= 1'b0;
            end
            if (w_nonzero && (r_digit_count != CNT_MAX)) begin
                r_digit_count <= r_digit_count + CNT_W'(1);
            end
        end
    end

    assign vec_out_plus  = r_out_plus;
    assign vec_out_minus = r_out_minus;
    assign out_valid     = r_out_valid;
    assign digit_err     = r_digit_err;
    assign err_sticky    = r_err_sticky;
    assign digit_count   = r_digit_count;

endmodule

// File: tb/tb_sdvm_div_pipe.sv
// Bench for sdvm_div_pipe: directed scenarios plus randomized traffic compared
// against a digit-queue reference model.
module tb_sdvm_div_pipe;

    localparam int NB      = 4;
    localparam int DLY     = 1;
    localparam int R4      = 1;
    localparam int CW      = 2;
    localparam int MASK    = (1 << NB) - 1;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          asyn_reset;
    logic          enable;
    logic [NB-1:0] vec_in_plus;
    logic [NB-1:0] vec_in_minus;
    logic [2:0]    digit_select;
    logic          in_valid;
    logic          clr_err;
    logic [NB-1:0] vec_out_plus;
    logic [NB-1:0] vec_out_minus;
    logic          out_valid;
    logic          digit_err;
    logic          err_sticky;
    logic [CW-1:0] digit_count;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [3:0] mq[$];
    int m_vp, m_vm, m_ov, m_de, m_es, m_cnt;

    sdvm_div_pipe #(
        .NUM_BITS(NB),
        .DELAY(DLY),
        .RADIX4(R4),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .asyn_reset(asyn_reset),
        .enable(enable),
        .vec_in_plus(vec_in_plus),
        .vec_in_minus(vec_in_minus),
        .digit_select(digit_select),
        .in_valid(in_valid),
        .clr_err(clr_err),
        .vec_out_plus(vec_out_plus),
        .vec_out_minus(vec_out_minus),
        .out_valid(out_valid),
        .digit_err(digit_err),
        .err_sticky(err_sticky),
        .digit_count(digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int apply_digit(input int x, input int mag, input bit neg);
        int y;
        y = (mag == 2) ? ((x << 1) & MASK) : x;
        if (neg) y = (~y) & MASK;
        return y;
    endfunction

    task automatic mdl_reset();
        mq.delete();
        for (int i = 0; i < DLY; i++) mq.push_back(4'b0000);
        m_vp = 0; m_vm = 0; m_ov = 0; m_de = 0; m_es = 0; m_cnt = 0;
    endtask

    // One enabled edge: the oldest queued digit meets the current operand.
    task automatic mdl_step(input bit en, input logic [2:0] sel, input bit vld,
                            input int vp, input int vm, input bit clr);
        logic [3:0] d;
        logic [1:0] code;
        int mag;
        if (!en) return;
        d = mq.pop_front();
        mq.push_back({sel, vld});
        code = d[2:1];
        mag  = (R4 != 0 && d[3]) ? 2 : 1;
        m_vp = 0; m_vm = 0; m_de = 0;
        m_ov = int'(d[0]);
        if (d[0]) begin
            if (code == 2'b10) begin
                m_vp = apply_digit(vp, mag, 1'b0);
                m_vm = apply_digit(vm, mag, 1'b0);
            end else if (code == 2'b01) begin
                m_vp = apply_digit(vp, mag, 1'b1);
                m_vm = apply_digit(vm, mag, 1'b1);
            end else if (code == 2'b11) begin
                m_de = 1;
            end
            if ((code == 2'b10 || code == 2'b01) && m_cnt < CNT_MAX) m_cnt++;
        end
        if (m_de == 1) m_es = 1;
        else if (clr) m_es = 0;
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".plus"},  64'(vec_out_plus),  64'(m_vp));
        chk({tag, ".minus"}, 64'(vec_out_minus), 64'(m_vm));
        chk({tag, ".valid"}, 64'(out_valid),     64'(m_ov));
        chk({tag, ".derr"},  64'(digit_err),     64'(m_de));
        chk({tag, ".stky"},  64'(err_sticky),    64'(m_es));
        chk({tag, ".cnt"},   64'(digit_count),   64'(m_cnt));
    endtask

    // Drive at negedge, clock, then compare 1 time unit after the rising edge.
    task automatic cycle(input string tag, input bit en, input logic [2:0] sel, input bit vld,
                         input logic [NB-1:0] vp, input logic [NB-1:0] vm, input bit clr);
        @(negedge clk);
        enable = en; digit_select = sel; in_valid = vld;
        vec_in_plus = vp; vec_in_minus = vm; clr_err = clr;
        @(posedge clk);
        mdl_step(en, sel, vld, int'(vp), int'(vm), clr);
        #1;
        cmp_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        #1;
        asyn_reset = 1'b1;
        #1;
        mdl_reset();
        chk({tag, ".plus"},  64'(vec_out_plus),  64'(0));
        chk({tag, ".minus"}, 64'(vec_out_minus), 64'(0));
        chk({tag, ".valid"}, 64'(out_valid),     64'(0));
        chk({tag, ".derr"},  64'(digit_err),     64'(0));
        chk({tag, ".stky"},  64'(err_sticky),    64'(0));
        chk({tag, ".cnt"},   64'(digit_count),   64'(0));
        #1;
        asyn_reset = 1'b0;
    endtask

    logic [NB-1:0] sv_p, sv_m;
    logic [CW-1:0] sv_c;
    logic          sv_s;

    initial begin
        n_checks = 0;
        n_errors = 0;
        asyn_reset = 1'b1;
        enable = 1'b0; digit_select = 3'b000; in_valid = 1'b0;
        vec_in_plus = '0; vec_in_minus = '0; clr_err = 1'b0;
        mdl_reset();
        #3;
        cmp_all("reset");
        @(negedge clk);
        asyn_reset = 1'b0;

        // +1, -1, -2 applied to 1010/0100
        cycle("d0",  1'b1, 3'b010, 1'b1, 4'b0000, 4'b0000, 1'b0);
        cycle("p1",  1'b1, 3'b001, 1'b1, 4'b1010, 4'b0100, 1'b0);
        chk("p1_plus", 64'(vec_out_plus), 64'(4'b1010));
        chk("p1_minus", 64'(vec_out_minus), 64'(4'b0100));
        chk("p1_valid", 64'(out_valid), 64'(1));
        chk("p1_cnt", 64'(digit_count), 64'(1));
        cycle("m1",  1'b1, 3'b101, 1'b1, 4'b1010, 4'b0100, 1'b0);
        chk("m1_plus", 64'(vec_out_plus), 64'(4'b0101));
        chk("m1_minus", 64'(vec_out_minus), 64'(4'b1011));
        cycle("m2",  1'b1, 3'b011, 1'b1, 4'b1010, 4'b0100, 1'b0);
        chk("m2_plus", 64'(vec_out_plus), 64'(4'b1011));
        chk("m2_minus", 64'(vec_out_minus), 64'(4'b0111));

        // Illegal digit, then clear colliding with another illegal digit
        cycle("ill1", 1'b1, 3'b011, 1'b1, 4'b1111, 4'b1111, 1'b0);
        chk("ill1_plus", 64'(vec_out_plus), 64'(0));
        chk("ill1_derr", 64'(digit_err), 64'(1));
        chk("ill1_stky", 64'(err_sticky), 64'(1));
        cycle("ill2", 1'b1, 3'b000, 1'b1, 4'b1111, 4'b1111, 1'b1);
        chk("ill2_stky", 64'(err_sticky), 64'(1));
        cycle("zero", 1'b1, 3'b010, 1'b1, 4'b0110, 4'b0011, 1'b0);
        chk("zero_derr", 64'(digit_err), 64'(0));
        chk("zero_stky", 64'(err_sticky), 64'(1));

        // Freeze for three cycles with clr_err asserted and new inputs
        sv_p = vec_out_plus; sv_m = vec_out_minus; sv_c = digit_count; sv_s = err_sticky;
        for (int i = 0; i < 3; i++) begin
            cycle("frz", 1'b0, 3'b001, 1'b1, NB'($urandom), NB'($urandom), 1'b1);
            chk("frz_plus", 64'(vec_out_plus), 64'(sv_p));
            chk("frz_minus", 64'(vec_out_minus), 64'(sv_m));
            chk("frz_cnt", 64'(digit_count), 64'(sv_c));
            chk("frz_stky", 64'(err_sticky), 64'(sv_s));
        end
        cycle("res1", 1'b1, 3'b001, 1'b1, 4'b0110, 4'b0011, 1'b0);
        chk("res1_plus", 64'(vec_out_plus), 64'(4'b0110));
        cycle("res2", 1'b1, 3'b000, 1'b0, 4'b0110, 4'b0011, 1'b1);
        chk("res2_plus", 64'(vec_out_plus), 64'(4'b1001));
        chk("res2_stky", 64'(err_sticky), 64'(0));

        // Counter saturation after a fresh reset
        pulse_reset("rst_a");
        for (int i = 0; i < 6; i++) begin
            cycle("sat", 1'b1, 3'b010, (i < 5), 4'b0001, 4'b0000, 1'b0);
            if (i >= 1) chk("sat_cnt", 64'(digit_count), 64'((i < 3) ? i : 3));
        end

        // Reset with a digit in flight: that digit must never appear
        cycle("fly", 1'b1, 3'b010, 1'b1, 4'b0101, 4'b0101, 1'b0);
        pulse_reset("rst_b");
        cycle("post", 1'b1, 3'b000, 1'b0, 4'b1111, 4'b1111, 1'b0);
        chk("post_valid", 64'(out_valid), 64'(0));
        chk("post_cnt", 64'(digit_count), 64'(0));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle("rnd", ($urandom_range(0, 9) < 7), 3'($urandom), 1'($urandom),
                  NB'($urandom), NB'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sdvm_div_pipe.md
SDVM_DIV_PIPE -- requirements
Module: sdvm_div_pipe

Interface
REQ-001 Parameter NUM_BITS, default 4: width of each redundant vector plane (legal 2..64).
REQ-002 Parameter DELAY, default 1: digit delay-line depth in stages (legal 1..8).
REQ-003 Parameter RADIX4, default 0: 0 = digit set {-1,0,+1}; 1 = digit set {-2..+2}.
REQ-004 Parameter CNT_W, default 8: width of the nonzero-digit counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 asyn_reset  input  1  reset, asynchronous, active-high.
REQ-007 enable  input  1  global advance; when low, all state holds.
REQ-008 vec_in_plus  input  NUM_BITS  positive plane of redundant operand.
REQ-009 vec_in_minus  input  NUM_BITS  negative plane of redundant operand.
REQ-010 digit_select  input  3  bit2 = magnitude-2 flag; bits[1:0]: 10 = +, 01 = -, 00 = zero, 11 = illegal.
REQ-011 in_valid  input  1  digit_select is valid this cycle.
REQ-012 clr_err  input  1  synchronous clear of err_sticky.
REQ-013 vec_out_plus  output  NUM_BITS  registered positive plane of result.
REQ-014 vec_out_minus  output  NUM_BITS  registered negative plane of result.
REQ-015 out_valid  output  1  result registers hold a valid product.
REQ-016 digit_err  output  1  current result came from an illegal digit code.
REQ-017 err_sticky  output  1  an illegal valid digit has reached the output since last clear.
REQ-018 digit_count  output  CNT_W  count of valid nonzero digits output, saturating.

Function
REQ-019 Digit path SHALL be a DELAY-stage shift register of {digit_select, in_valid}, advancing only on edges with enable=1.
REQ-020 Output registers SHALL load on an enable=1 edge from the last delay stage and the vec_in planes present at that same edge.
REQ-021 Latency: digit at edge k SHALL produce output at edge k+DELAY when enable stays high; vec_in is combined at edge k+DELAY.
REQ-022 Code 10: out planes SHALL equal the inputs unchanged.
REQ-023 Code 01: out planes SHALL equal the bitwise complement of each input plane.
REQ-024 Code 00: out planes SHALL be all zero.
REQ-025 Code 11: out planes SHALL be all zero, and digit_err SHALL be 1 if the stage is valid.
REQ-026 RADIX4=1 and bit2=1 with code 10/01: each plane SHALL be shifted left one bit (LSB filled 0, MSB dropped) before any complement, so -2 gives LSB=1 in both planes.
REQ-027 RADIX4=0: bit2 SHALL be ignored.
REQ-028 out_valid SHALL equal the valid bit of the stage that produced the output register contents.
REQ-029 Invalid stage (valid=0): out planes SHALL load zero, digit_err 0, no count.
REQ-030 err_sticky SHALL set on any edge loading digit_err=1 and clear only on clr_err=1 or reset; simultaneous set and clear: set wins.
REQ-031 digit_count SHALL increment on each load of a valid digit with code 10/01 and hold at 2^CNT_W-1.
REQ-032 enable=0 SHALL freeze delay line, outputs, err_sticky and digit_count; clr_err SHALL be ignored.

Reset
REQ-033 asyn_reset=1 SHALL immediately clear all delay stages, vec_out_plus, vec_out_minus, out_valid, digit_err, err_sticky and digit_count to 0, independent of clk and enable.
REQ-034 Reset mid-operation SHALL discard all in-flight digits; first valid output after release SHALL come only from digits sampled after release.

Verification (NUM_BITS=4, DELAY=1, RADIX4=1, CNT_W=2)
REQ-035 digit 010 valid at edge 0, vec_in 1010/0100 at edge 1 -> after edge 1: out 1010/0100, out_valid=1, digit_count=1.
REQ-036 digit 001 valid, vec_in 1010/0100 -> out 0101/1011; digit 101 (-2) same vec -> out 1011/0111.
REQ-037 digit 011 valid -> out 0000/0000, digit_err=1, err_sticky=1 persisting; clr_err and a new illegal digit on the same edge -> err_sticky stays 1.
REQ-038 five consecutive valid +1 digits -> digit_count 1,2,3,3,3 (saturates).
REQ-039 enable low for 3 cycles mid-stream -> all outputs frozen, stream resumes with no lost or duplicated digit.
REQ-040 asyn_reset pulsed between clock edges with a digit in flight -> all outputs 0 immediately; no output from that digit after release.
